// File: rtl/prog_pkg.sv
// Shared constants and FSM state encoding for the program loader.
// The optional checksum trailer is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_pkg;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_AHI  = 4'd1,
    S_ALO  = 4'd2,
    S_LHI  = 4'd3,
    S_LLO  = 4'd4,
    S_DATA = 4'd5,
    S_CSUM = 4'd6,
    S_DONE = 4'd7,
    S_ERR  = 4'd8
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Loads a framed byte stream into program memory and restarts the PC at the frame's start address.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module prog_loader
  import prog_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          pc_load,
  output logic [AW-1:0] pc_inpload
);

  state_t        state_reg;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] len_reg;
  logic          accept;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic [7:0] csum_next;

  always_comb begin
    csum_next = sum_reg + rx_data;
  end
`endif

  // Terminal states spend exactly one cycle pulsing status, so no byte is taken there.
  assign rx_ready = (state_reg != S_DONE) && (state_reg != S_ERR);
  assign busy     = (state_reg != S_IDLE);
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      pc_load    <= 1'b0;
      pc_inpload <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      mem_we  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pc_load <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept && rx_data == SYNC) begin
            state_reg <= S_AHI;
            addr_reg  <= '0;
            len_reg   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
          end
        end
        S_AHI: begin
          if (accept) begin
            addr_reg[11:8] <= rx_data[3:0];
            if (rx_data[7:4] != 4'd0) begin
              state_reg <= S_ERR;
              err       <= 1'b1;
            end else begin
              state_reg <= S_ALO;
            end
          end
        end
        S_ALO: begin
          if (accept) begin
            addr_reg[7:0] <= rx_data;
            state_reg     <= S_LHI;
          end
        end
        S_LHI: begin
          if (accept) begin
            len_reg[11:8] <= rx_data[3:0];
            if (rx_data[7:4] != 4'd0) begin
              state_reg <= S_ERR;
              err       <= 1'b1;
            end else begin
              state_reg <= S_LLO;
            end
          end
        end
        S_LLO: begin
          if (accept) begin
            len_reg[7:0] <= rx_data;
            pc_inpload   <= addr_reg;
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          // len counts remaining bytes minus one, so the byte taken at len==0 is the last.
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_reg;
            mem_wdata <= rx_data;
            addr_reg  <= addr_reg + 1'b1;
            len_reg   <= len_reg - 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_reg   <= csum_next;
            if (len_reg == '0) begin
              state_reg <= S_CSUM;
            end
`else
            if (len_reg == '0) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              pc_load   <= 1'b1;
            end
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (csum_next == 8'd0) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              pc_load   <= 1'b1;
            end else begin
              state_reg <= S_ERR;
              err       <= 1'b1;
            end
          end
        end
`endif
        S_DONE:  state_reg <= S_IDLE;
        S_ERR:   state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frames, wrap, errors, backpressure, reset abort.
// Checksum scenarios run when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        pc_load;
  logic [11:0] pc_inpload;

  int tests = 0;
  int failed = 0;

  logic [7:0]  mem_model [0:4095];
  int          cyc = 0;
  int          we_cyc[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          pl_cnt = 0;
  int          done_cyc = -1;
  int          pl_cyc = -1;
  logic [11:0] done_pc = '0;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc_load    (pc_load),
    .pc_inpload (pc_inpload)
  );

  always #5 clk = ~clk;

  // The program memory itself plus pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      mem_model[mem_addr] = mem_wdata;
      we_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_pc  = pc_inpload;
    end
    if (err) err_cnt++;
    if (pc_load) begin
      pl_cnt++;
      pl_cyc = cyc;
    end
  end

  task automatic clear_counts();
    we_cyc.delete();
    done_cnt = 0;
    err_cnt  = 0;
    pl_cnt   = 0;
    done_cyc = -1;
    pl_cyc   = -1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: rx_ready=%0b after %0d cycles, required 1 (byte %h)", rx_ready, n, b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    tests++;
    if ({mem_we, done, err, pc_load, busy} !== 5'b0) begin
      failed++;
      $display("FAIL reset_flags: we,done,err,pc_load,busy=%b required 00000", {mem_we, done, err, pc_load, busy});
    end
    tests++;
    if ({mem_addr, mem_wdata, pc_inpload} !== 32'h0) begin
      failed++;
      $display("FAIL reset_values: addr=%h wdata=%h pc=%h required 0", mem_addr, mem_wdata, pc_inpload);
    end
    tests++;
    if (rx_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: rx_ready=%b required 1", rx_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    logic [7:0] f [0:7];
    f = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    clear_counts();
    for (int i = 0; i < 8; i++) send(f[i], 0);
    idle(4);
    tests++;
    if (we_cyc.size() !== 3) begin
      failed++;
      $display("FAIL basic_we_count: %0d writes, required 3", we_cyc.size());
    end else begin
      tests++;
      if (we_cyc[1] !== we_cyc[0] + 1 || we_cyc[2] !== we_cyc[0] + 2) begin
        failed++;
        $display("FAIL basic_we_consecutive: cycles %0d,%0d,%0d required consecutive", we_cyc[0], we_cyc[1], we_cyc[2]);
      end
      tests++;
      if (done_cyc !== we_cyc[2] || pl_cyc !== we_cyc[2]) begin
        failed++;
        $display("FAIL basic_done_timing: done@%0d pc_load@%0d required both @%0d", done_cyc, pl_cyc, we_cyc[2]);
      end
    end
    tests++;
    if ({mem_model[12'h120], mem_model[12'h121], mem_model[12'h122]} !== 24'h112233) begin
      failed++;
      $display("FAIL basic_mem: %h %h %h required 11 22 33", mem_model[12'h120], mem_model[12'h121], mem_model[12'h122]);
    end
    tests++;
    if (done_cnt !== 1 || pl_cnt !== 1 || err_cnt !== 0) begin
      failed++;
      $display("FAIL basic_pulses: done=%0d pc_load=%0d err=%0d required 1 1 0", done_cnt, pl_cnt, err_cnt);
    end
    tests++;
    if (done_pc !== 12'h120) begin
      failed++;
      $display("FAIL basic_pc: pc_inpload=%h required 120", done_pc);
    end
    tests++;
    if (mem_addr !== 12'h122 || mem_wdata !== 8'h33 || busy !== 1'b0) begin
      failed++;
      $display("FAIL basic_hold: addr=%h wdata=%h busy=%b required 122 33 0", mem_addr, mem_wdata, busy);
    end
    $display("[TB] frame basic addr=120 len=3 sent");
  endtask

  task automatic test_wrap();
    logic [7:0] f [0:6];
    f = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'hAA, 8'hBB};
    clear_counts();
    for (int i = 0; i < 7; i++) send(f[i], 0);
    idle(4);
    tests++;
    if (mem_model[12'hFFF] !== 8'hAA || mem_model[12'h000] !== 8'hBB) begin
      failed++;
      $display("FAIL wrap_mem: [FFF]=%h [000]=%h required AA BB", mem_model[12'hFFF], mem_model[12'h000]);
    end
    tests++;
    if (done_cnt !== 1 || err_cnt !== 0 || done_pc !== 12'hFFF) begin
      failed++;
      $display("FAIL wrap_done: done=%0d err=%0d pc=%h required 1 0 FFF", done_cnt, err_cnt, done_pc);
    end
    $display("[TB] frame wrap addr=FFF len=2 sent");
  endtask

  task automatic test_errors();
    clear_counts();
    send(8'hA5, 0);
    send(8'h1F, 0);
    idle(4);
    tests++;
    if (err_cnt !== 1 || pl_cnt !== 0 || done_cnt !== 0 || we_cyc.size() !== 0) begin
      failed++;
      $display("FAIL err_header: err=%0d pc_load=%0d done=%0d we=%0d required 1 0 0 0", err_cnt, pl_cnt, done_cnt, we_cyc.size());
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL err_idle: busy=%b required 0", busy);
    end
    $display("[TB] frame bad AHI=1F sent");

    clear_counts();
    send(8'h00, 0);
    send(8'h7E, 0);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL junk_busy: busy=%b required 0", busy);
    end
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h5C, 0);
    idle(4);
    tests++;
    if (mem_model[12'h200] !== 8'h5C || done_cnt !== 1 || done_pc !== 12'h200 || err_cnt !== 0) begin
      failed++;
      $display("FAIL junk_frame: [200]=%h done=%0d pc=%h err=%0d required 5C 1 200 0", mem_model[12'h200], done_cnt, done_pc, err_cnt);
    end
    $display("[TB] frame after junk addr=200 len=1 sent");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_counts();
    send(8'hA5, 1);
    send(8'h03, 2);
    send(8'h00, 0);
    send(8'h00, 1);
    send(8'h0F, 2);
    for (int i = 0; i < 16; i++) send(8'(i * 7 + 3), int'($urandom_range(0, 3)));
    idle(4);
    for (int i = 0; i < 16; i++) begin
      if (mem_model[12'h300 + 12'(i)] !== 8'(i * 7 + 3)) bad++;
    end
    tests++;
    if (bad !== 0) begin
      failed++;
      $display("FAIL bp_mem: %0d wrong bytes at 300..30F, required 0", bad);
    end
    tests++;
    if (done_cnt !== 1 || pl_cnt !== 1 || we_cyc.size() !== 16) begin
      failed++;
      $display("FAIL bp_pulses: done=%0d pc_load=%0d we=%0d required 1 1 16", done_cnt, pl_cnt, we_cyc.size());
    end
    $display("[TB] frame backpressure addr=300 len=16 sent");
  endtask

  task automatic test_reset_abort();
    clear_counts();
    send(8'hA5, 0);
    send(8'h04, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h09, 0);
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 0);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    tests++;
    if ({mem_we, done, err, pc_load, busy} !== 5'b0 || {mem_addr, mem_wdata, pc_inpload} !== 32'h0) begin
      failed++;
      $display("FAIL abort_outputs: we,done,err,pc_load,busy=%b addr=%h wdata=%h pc=%h required all 0",
               {mem_we, done, err, pc_load, busy}, mem_addr, mem_wdata, pc_inpload);
    end
    tests++;
    if ({mem_model[12'h400], mem_model[12'h401], mem_model[12'h402], mem_model[12'h403]} !== 32'h40414243) begin
      failed++;
      $display("FAIL abort_mem: 400..403=%h %h %h %h required 40 41 42 43",
               mem_model[12'h400], mem_model[12'h401], mem_model[12'h402], mem_model[12'h403]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    clear_counts();
    send(8'hA5, 0);
    send(8'h05, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hC1, 0);
    send(8'hC2, 0);
    idle(4);
    tests++;
    if (mem_model[12'h500] !== 8'hC1 || mem_model[12'h501] !== 8'hC2 || done_cnt !== 1 || done_pc !== 12'h500) begin
      failed++;
      $display("FAIL abort_recover: [500]=%h [501]=%h done=%0d pc=%h required C1 C2 1 500",
               mem_model[12'h500], mem_model[12'h501], done_cnt, done_pc);
    end
    $display("[TB] frame aborted by reset, then addr=500 len=2 sent");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_counts();
    send(8'hA5, 0);
    send(8'h06, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'hD0, 0);
    idle(4);
    tests++;
    if (done_cnt !== 1 || err_cnt !== 0 || pl_cnt !== 1 || mem_model[12'h600] !== 8'h10 || mem_model[12'h601] !== 8'h20) begin
      failed++;
      $display("FAIL csum_good: done=%0d err=%0d pc_load=%0d mem=%h %h required 1 0 1 10 20",
               done_cnt, err_cnt, pl_cnt, mem_model[12'h600], mem_model[12'h601]);
    end
    clear_counts();
    send(8'hA5, 0);
    send(8'h06, 0);
    send(8'h10, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'hD1, 0);
    idle(4);
    tests++;
    if (done_cnt !== 0 || err_cnt !== 1 || pl_cnt !== 0 || mem_model[12'h610] !== 8'h10 || mem_model[12'h611] !== 8'h20) begin
      failed++;
      $display("FAIL csum_bad: done=%0d err=%0d pc_load=%0d mem=%h %h required 0 1 0 10 20",
               done_cnt, err_cnt, pl_cnt, mem_model[12'h610], mem_model[12'h611]);
    end
    $display("[TB] checksum frames D0 and D1 sent");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_errors();
    test_backpressure();
    test_reset_abort();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program ROM/fetch path. Receives a framed byte stream over a valid/ready handshake and writes it into the 4096x8 program memory that the fetch path reads.
- On completion, pulses the program counter's load input with the frame's start address, so the counter restarts at the loaded program.

Parameters:
- AW, 12, address width of program memory and PC
- DW, 8, data width of one instruction byte (instr[7:4] | oprnd[3:0])
- SYNC, 8'hA5, frame start byte

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rx_valid  in  1  source has a byte on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts rx_data this cycle
- mem_we  out  1  program memory write strobe, one cycle per byte
- mem_addr  out  12  write address
- mem_wdata  out  8  write data
- busy  out  1  frame in progress (state != S_IDLE)
- done  out  1  one-cycle pulse on frame success
- err  out  1  one-cycle pulse on frame error
- pc_load  out  1  one-cycle pulse to PC load input
- pc_inpload  out  12  PC load value (frame start address), held stable

Behaviour:
- Reset (reset=0, async) values:
  - state=S_IDLE.
  - All outputs 0, including mem_addr, mem_wdata, pc_inpload.
  - Internal addr, len and sum registers are 0.
  - Reset mid-frame aborts the frame. Bytes already written stay in memory.
- Handshake:
  - A byte is accepted when rx_valid && rx_ready on a rising clk edge.
  - rx_ready=1 in S_IDLE, S_AHI, S_ALO, S_LHI, S_LLO, S_DATA and S_CSUM.
  - rx_ready=0 in S_DONE and S_ERR.
- Frame format: SYNC, AHI, ALO, LHI, LLO, then N data bytes, where N = {LHI[3:0],LLO}+1 (range 1..4096).
- FSM transitions (each taken only on an accepted byte unless stated):
  - S_IDLE: byte==SYNC -> S_AHI. Any other byte is dropped silently and the FSM stays in S_IDLE.
  - S_AHI: addr[11:8]=byte[3:0]. If byte[7:4]!=0 -> S_ERR, else -> S_ALO.
  - S_ALO: addr[7:0]=byte -> S_LHI.
  - S_LHI: len[11:8]=byte[3:0]. If byte[7:4]!=0 -> S_ERR, else -> S_LLO.
  - S_LLO: len[7:0]=byte. pc_inpload<=addr (start address latched) -> S_DATA.
  - S_DATA: each byte is written (see write timing below); addr<=addr+1 and len<=len-1.
    - After the byte accepted with len==0 -> S_CSUM when CHECKSUM_EN is defined, else S_DONE.
  - S_DONE (one cycle, no byte needed): done=1, pc_load=1 -> S_IDLE.
  - S_ERR (one cycle, no byte needed): err=1 -> S_IDLE. pc_load stays 0.
- Write timing:
  - Registered, latency 1. The cycle after a data byte is accepted: mem_we=1, mem_addr=address of that byte, mem_wdata=that byte.
  - Back-to-back accepts give mem_we high on consecutive cycles.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- Address wrap: addr is modulo 4096, so 12'hFFF+1 -> 12'h000. No error is raised on wrap.
- A SYNC byte seen inside S_DATA is ordinary data. There is no resync mid-frame.
- rx_valid may drop at any point; the FSM waits in its current state indefinitely.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit sum (mod 256) accumulates every data byte.
  - S_CSUM accepts one extra byte. If (sum + byte) mod 256 == 0 -> S_DONE, else -> S_ERR.
  - On error, memory is already written but pc_load is not issued.
- Undefined: S_CSUM and the sum register do not exist; S_DATA goes directly to S_DONE.

Decomposition:
- Shared package prog_pkg:
  - AW and DW constants, SYNC.
  - State encoding S_IDLE, S_AHI, S_ALO, S_LHI, S_LLO, S_DATA, S_CSUM, S_DONE, S_ERR (4-bit).
- No sub-module. The FSM, counters and write register form one block.

Test Plan:
- Basic frame: A5,01,20,00,02,11,22,33 with no stalls -> mem_we pulses 3 cycles, writing 0x120=11, 0x121=22, 0x122=33. Then done=1 and pc_load=1 with pc_inpload=0x120, all for one cycle.
- Address wrap: A5,0F,FF,00,01,AA,BB -> writes 0xFFF=AA and 0x000=BB; done pulses.
- Errors and garbage:
  - Header A5,1F,... -> err pulse after AHI; no mem_we, no pc_load.
  - Leading junk bytes 00,7E before A5 are dropped, and the following frame loads correctly.
- Backpressure and reset:
  - Random rx_valid gaps in a 16-byte frame -> identical memory contents and a single done pulse.
  - reset=0 after 5 data bytes -> all outputs 0 and busy=0 immediately.
  - A new frame after reset then completes normally.
- With PROG_LOADER_CHECKSUM_EN:
  - Frame data 10,20 plus checksum D0 -> done.
  - Checksum D1 -> err; 0x...=10,20 still written; no pc_load.
